// File: rtl/d7s_pkg.sv
// Shared definitions for the D7S display driver and its scan decoder:
// digit count, segment pattern constants, blank code, FSM state type and
// the packed pin bundle carried through the input synchronizer.
package d7s_pkg;

    localparam int unsigned NUM_DIGITS = 3;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned SEL_W      = NUM_DIGITS;
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned DIG_W      = NUM_DIGITS * BCD_W;

    // Active-high segment patterns, bit6=a .. bit0=g
    localparam logic [SEG_W-1:0] SEG_0     = 7'h7E;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h33;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h5F;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h70;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h7B;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } d7s_state_e;

    // Sampled display pins: digit select above segments
    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [SEG_W-1:0] seg;
    } d7s_pins_t;

endpackage

// File: rtl/d7s_seg2bcd.sv
// Segment pattern to BCD decoder (combinational).
//   seg       : active-high segments {a,b,c,d,e,f,g}
//   bcd_c     : 0-9, or BCD_BLANK for an all-off or unknown pattern
//   invalid_c : pattern is neither a digit nor blank
module d7s_seg2bcd
    import d7s_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [BCD_W-1:0] bcd_c,
    output logic             invalid_c
);

    always_comb begin
        bcd_c     = BCD_BLANK;
        invalid_c = 1'b0;
        case (seg)
            SEG_0:     bcd_c = 4'd0;
            SEG_1:     bcd_c = 4'd1;
            SEG_2:     bcd_c = 4'd2;
            SEG_3:     bcd_c = 4'd3;
            SEG_4:     bcd_c = 4'd4;
            SEG_5:     bcd_c = 4'd5;
            SEG_6:     bcd_c = 4'd6;
            SEG_7:     bcd_c = 4'd7;
            SEG_8:     bcd_c = 4'd8;
            SEG_9:     bcd_c = 4'd9;
            SEG_BLANK: bcd_c = BCD_BLANK;
            default:   invalid_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/d7s_scan_decoder.sv
// Receive side of the multiplexed 7-segment display: synchronizes the segment
// and digit-select pins, waits for each dwell to be stable, then decodes the
// pattern back to BCD for the selected digit.
//   clk, rst_n   : clock, synchronous active-low reset
//   seg_in       : segments {a..g}, bit6=a
//   sel_in       : one-hot digit select, bit k = digit k
//   err_clr      : clears the sticky error flags
//   digits_o     : {dig2,dig1,dig0} BCD, 4'hF = blank
//   dig_valid_o  : digit k captured at least once
//   frame_o      : one-cycle pulse once every digit has been captured
//   bad_seg_o    : sticky, undecodable stable pattern seen
//   bad_sel_o    : sticky, multi-hot stable select seen
module d7s_scan_decoder
    import d7s_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter bit          SEG_ACT_LOW   = 1'b0,
    parameter bit          SEL_ACT_LOW   = 1'b0
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEG_W-1:0] seg_in,
    input  logic [SEL_W-1:0] sel_in,
    input  logic             err_clr,
    output logic [DIG_W-1:0] digits_o,
    output logic [SEL_W-1:0] dig_valid_o,
    output logic             frame_o,
    output logic             bad_seg_o,
    output logic             bad_sel_o
);

    localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    d7s_pins_t        sync_meta;
    d7s_pins_t        sync_q;
    d7s_pins_t        prev_q;
    d7s_pins_t        cap_q;
    d7s_pins_t        pins_pol_c;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt_c;
    logic             stb_c;
    d7s_state_e       state;
    logic [SEL_W-1:0] mask;
    logic [SEL_W-1:0] mask_set_c;
    logic             sel_onehot_c;
    logic             sel_multi_c;
    logic [BCD_W-1:0] bcd_c;
    logic             seg_invalid_c;
    logic [DIG_W-1:0] dig_wmask_c;
    logic             set_seg_c;
    logic             set_sel_c;

    // Polarity is normalised after the synchronizer
    always_comb begin
        pins_pol_c = sync_q;
        if (SEG_ACT_LOW) pins_pol_c.seg = ~sync_q.seg;
        if (SEL_ACT_LOW) pins_pol_c.sel = ~sync_q.sel;
    end

    // Stability counter; stb fires only on the cycle the count reaches the limit
    always_comb begin
        cnt_nxt_c = cnt;
        if (sync_q != prev_q) begin
            cnt_nxt_c = '0;
        end else if (cnt < CNT_MAX) begin
            cnt_nxt_c = cnt + CNT_W'(1);
        end
        stb_c = (cnt_nxt_c == CNT_MAX) && (cnt != CNT_MAX);
    end

    d7s_seg2bcd u_seg2bcd (
        .seg       (cap_q.seg),
        .bcd_c     (bcd_c),
        .invalid_c (seg_invalid_c)
    );

    // Classification of the captured select and the resulting write masks
    always_comb begin
        sel_onehot_c = (cap_q.sel != '0) && ((cap_q.sel & (cap_q.sel - SEL_W'(1))) == '0);
        sel_multi_c  = (cap_q.sel != '0) && !sel_onehot_c;
        mask_set_c   = mask | cap_q.sel;
        dig_wmask_c  = {{BCD_W{cap_q.sel[2]}}, {BCD_W{cap_q.sel[1]}}, {BCD_W{cap_q.sel[0]}}};
        set_seg_c    = (state == EVAL) && sel_onehot_c && seg_invalid_c;
        set_sel_c    = (state == EVAL) && sel_multi_c;
    end

    // Synchronizer, counter, capture FSM, mask/frame and sticky errors
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_meta   <= '0;
            sync_q      <= '0;
            prev_q      <= '0;
            cap_q       <= '0;
            cnt         <= '0;
            state       <= WAIT;
            mask        <= '0;
            digits_o    <= '1;
            dig_valid_o <= '0;
            frame_o     <= 1'b0;
            bad_seg_o   <= 1'b0;
            bad_sel_o   <= 1'b0;
        end else begin
            sync_meta <= d7s_pins_t'({sel_in, seg_in});
            sync_q    <= sync_meta;
            prev_q    <= sync_q;
            cnt       <= cnt_nxt_c;
            frame_o   <= 1'b0;
            // A new error in the same cycle as err_clr keeps its flag set
            bad_seg_o <= set_seg_c | (bad_seg_o & ~err_clr);
            bad_sel_o <= set_sel_c | (bad_sel_o & ~err_clr);

            case (state)
                WAIT: begin
                    if (stb_c) begin
                        cap_q <= pins_pol_c;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    if (sel_onehot_c) begin
                        digits_o    <= (digits_o & ~dig_wmask_c) | ({NUM_DIGITS{bcd_c}} & dig_wmask_c);
                        dig_valid_o <= dig_valid_o | cap_q.sel;
                        if (mask_set_c == '1) begin
                            frame_o <= 1'b1;
                            mask    <= '0;
                        end else begin
                            mask <= mask_set_c;
                        end
                    end
                    state <= HOLD;
                end
                HOLD: begin
                    // One capture per dwell: re-arm only after the pins move
                    if (cnt == '0) state <= WAIT;
                end
                default: state <= WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_d7s_scan_decoder.sv
// Scoreboard bench: stimulus pushes time-stamped expected output snapshots,
// a monitor applies them and compares two instances (active-high pins and
// fully inverted pins with active-low parameters) every cycle.
module tb_d7s_scan_decoder;

    localparam int unsigned S = 16;
    localparam logic [6:0] PAT [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                        7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    localparam logic [2:0] MULTI [4] = '{3'b011, 3'b101, 3'b110, 3'b111};

    typedef struct {
        int          due;
        logic [11:0] dig;
        logic [2:0]  val;
        logic        frame;
        logic        bseg;
        logic        bsel;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg;
    logic [2:0]  sel;
    logic        err_clr;
    logic [6:0]  seg_n;
    logic [2:0]  sel_n;
    logic [11:0] a_dig, b_dig;
    logic [2:0]  a_val, b_val;
    logic        a_frame, b_frame, a_bseg, b_bseg, a_bsel, b_bsel;

    assign seg_n = ~seg;
    assign sel_n = ~sel;

    d7s_scan_decoder #(.STABLE_CYCLES(S), .SEG_ACT_LOW(1'b0), .SEL_ACT_LOW(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg), .sel_in(sel), .err_clr(err_clr),
        .digits_o(a_dig), .dig_valid_o(a_val), .frame_o(a_frame),
        .bad_seg_o(a_bseg), .bad_sel_o(a_bsel));

    d7s_scan_decoder #(.STABLE_CYCLES(S), .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b1)) u_dut_inv (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_n), .sel_in(sel_n), .err_clr(err_clr),
        .digits_o(b_dig), .dig_valid_o(b_val), .frame_o(b_frame),
        .bad_seg_o(b_bseg), .bad_sel_o(b_bsel));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t cur;
    logic started = 1'b0;

    // Reference model state
    logic [3:0] m_dig [3];
    logic [2:0] m_val, m_mask;
    logic       m_bseg, m_bsel;
    logic [9:0] prev_pins;

    function automatic logic [4:0] ref_dec(input logic [6:0] s);
        for (int i = 0; i < 10; i++) if (PAT[i] == s) return {1'b0, 4'(i)};
        if (s == 7'h00) return {1'b0, 4'hF};
        return {1'b1, 4'hF};
    endfunction

    function automatic exp_t snap(input int due, input logic frame);
        exp_t e;
        e.due = due; e.dig = {m_dig[2], m_dig[1], m_dig[0]}; e.val = m_val;
        e.frame = frame; e.bseg = m_bseg; e.bsel = m_bsel;
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) m_dig[k] = 4'hF;
        m_val = 3'b000; m_mask = 3'b000; m_bseg = 1'b0; m_bsel = 1'b0;
    endtask

    // One capture and/or error clear taking effect at the same edge
    task automatic model_event(input logic do_cap, input logic [2:0] s, input logic [6:0] g,
                               input logic do_clr, output logic frame);
        logic set_seg, set_sel;
        logic [4:0] d;
        frame = 1'b0; set_seg = 1'b0; set_sel = 1'b0;
        if (do_cap) begin
            if ($countones(s) == 1) begin
                for (int k = 0; k < 3; k++) begin
                    if (s[k]) begin
                        d = ref_dec(g);
                        m_dig[k] = d[3:0];
                        set_seg = d[4];
                        m_val[k] = 1'b1;
                        m_mask[k] = 1'b1;
                    end
                end
                if (m_mask == 3'b111) begin
                    frame = 1'b1;
                    m_mask = 3'b000;
                end
            end else if ($countones(s) > 1) begin
                set_sel = 1'b1;
            end
        end
        if (do_clr) begin
            m_bseg = set_seg; m_bsel = set_sel;
        end else begin
            m_bseg = m_bseg | set_seg; m_bsel = m_bsel | set_sel;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic reset_for(input int n);
        rst_n = 1'b0; sel = 3'b000; seg = 7'h00; err_clr = 1'b0; prev_pins = '0;
        model_reset();
        q.push_back(snap(cyc + 1, 1'b0));
        idle(n);
        rst_n = 1'b1;
    endtask

    // Hold {s,g} for len cycles; optionally pulse err_clr at offset clr_off
    task automatic dwell(input logic [2:0] s, input logic [6:0] g, input int len, input int clr_off);
        int   c0, dcap, dclr;
        logic cap, fr;
        sel = s; seg = g; prev_pins = {s, g};
        c0 = cyc;
        cap = (len >= int'(S) + 1);
        dcap = int'(S) + 4;
        dclr = clr_off + 1;
        if (clr_off >= 0 && cap && dclr == dcap) begin
            model_event(1'b1, s, g, 1'b1, fr);
            q.push_back(snap(c0 + dcap, fr));
        end else begin
            if (clr_off >= 0 && (!cap || dclr < dcap)) begin
                model_event(1'b0, s, g, 1'b1, fr);
                q.push_back(snap(c0 + dclr, fr));
            end
            if (cap) begin
                model_event(1'b1, s, g, 1'b0, fr);
                q.push_back(snap(c0 + dcap, fr));
            end
            if (clr_off >= 0 && cap && dclr > dcap) begin
                model_event(1'b0, s, g, 1'b1, fr);
                q.push_back(snap(c0 + dclr, fr));
            end
        end
        for (int i = 0; i < len; i++) begin
            err_clr = (i == clr_off);
            @(posedge clk); #1;
        end
        err_clr = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s cyc=%0d got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: apply due snapshots, compare both instances every cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due < cyc) begin
            checks++; errors++;
            $display("FAIL sched cyc=%0d got unapplied entry due %0d expected none", cyc, q[0].due);
            q.delete(0);
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            cur = q.pop_front();
            started = 1'b1;
        end else begin
            cur.frame = 1'b0;
        end
        if (started) begin
            chk("digits",      a_dig,          cur.dig);
            chk("dig_valid",   12'(a_val),     12'(cur.val));
            chk("frame",       12'(a_frame),   12'(cur.frame));
            chk("bad_seg",     12'(a_bseg),    12'(cur.bseg));
            chk("bad_sel",     12'(a_bsel),    12'(cur.bsel));
            chk("inv_digits",  b_dig,          cur.dig);
            chk("inv_valid",   12'(b_val),     12'(cur.val));
            chk("inv_frame",   12'(b_frame),   12'(cur.frame));
            chk("inv_bad_seg", 12'(b_bseg),    12'(cur.bseg));
            chk("inv_bad_sel", 12'(b_bsel),    12'(cur.bsel));
        end
    end

    initial begin
        logic [2:0] s;
        logic [6:0] g;
        int         len, co, r;

        reset_for(3);
        idle(S + 8);

        // Single capture, then a full 2/5/9 frame
        dwell(3'b001, 7'h30, 20, -1);
        dwell(3'b001, 7'h6D, 20, -1);
        dwell(3'b010, 7'h5B, 20, -1);
        dwell(3'b100, 7'h7B, 20, -1);

        // Short glitch to 8 inside a 5 dwell
        dwell(3'b001, 7'h5B, 8, -1);
        dwell(3'b001, 7'h7F, 3, -1);
        dwell(3'b001, 7'h5B, 20, -1);

        // Dwell length boundary: S cycles misses, S+1 captures
        dwell(3'b010, 7'h7E, S, -1);
        dwell(3'b010, 7'h30, S + 1, -1);
        dwell(3'b100, 7'h7E, 20, -1);

        // Error flags, clear, and clear coincident with a new error
        dwell(3'b001, 7'h01, 20, -1);
        dwell(3'b011, 7'h7E, 20, -1);
        dwell(3'b000, 7'h7E, 20, 5);
        dwell(3'b110, 7'h30, 20, -1);
        dwell(3'b010, 7'h01, 20, S + 3);
        dwell(3'b001, 7'h79, 20, -1);

        // Reset in the middle of a dwell (cnt at 10)
        sel = 3'b001; seg = 7'h5F; prev_pins = {3'b001, 7'h5F};
        idle(13);
        reset_for(2);
        idle(S + 8);

        for (int n = 0; n < 60; n++) begin
            do begin
                r = $urandom_range(0, 99);
                if (r < 70)      s = 3'(3'b001 << $urandom_range(0, 2));
                else if (r < 80) s = 3'b000;
                else             s = MULTI[$urandom_range(0, 3)];
                r = $urandom_range(0, 99);
                if (r < 80 || $countones(s) != 1) g = PAT[$urandom_range(0, 9)];
                else if (r < 90)                  g = 7'h00;
                else                              g = 7'($urandom_range(0, 127));
            end while ({s, g} == prev_pins);
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, S)) : int'($urandom_range(S + 1, S + 6));
            co  = (len >= 4 && $urandom_range(0, 9) == 0) ? int'($urandom_range(3, len - 1)) : -1;
            dwell(s, g, len, co);
        end

        idle(S + 8);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending entries expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
